// File: rtl/store_unit_pkg.sv
// Shared types and lane constants for the store unit (SW/SH/SB into word memory).
// The STORE_UNIT_ALIGN_CHECK_EN macro is consumed by store_unit.
package store_pkg;

  typedef enum logic [1:0] {
    ST_SW   = 2'b00,
    ST_SH   = 2'b01,
    ST_SB   = 2'b10,
    ST_RSVD = 2'b11
  } stype_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Big-endian: byte offset 0 is the most significant byte of the word.
  localparam int unsigned BYTE0_LSB = 24;
  localparam int unsigned BYTE1_LSB = 16;
  localparam int unsigned BYTE2_LSB = 8;
  localparam int unsigned BYTE3_LSB = 0;
  localparam int unsigned HALF0_LSB = 16;
  localparam int unsigned HALF1_LSB = 0;

endpackage

// File: rtl/store_unit_if.sv
// Request and memory-bus signals of the store unit; slave is the store unit side.
interface store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              Start;
  logic [1:0]        SType;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       WData;
  logic [31:0]       MemData;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWData;
  logic              MemRead;
  logic              MemWrite;
  logic              Busy;
  logic              Done;
  logic              StoreErr;

  modport master (
    output Start, SType, Addr, WData, MemData,
    input  MemAddr, MemWData, MemRead, MemWrite, Busy, Done, StoreErr
  );

  modport slave (
    input  Start, SType, Addr, WData, MemData,
    output MemAddr, MemWData, MemRead, MemWrite, Busy, Done, StoreErr
  );
endinterface

// File: rtl/store_unit_merge.sv
// Big-endian byte/halfword lane merge of store data into an old memory word.
module store_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [15:0] wdata,
  input  stype_t      stype,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  // Replace only the addressed lane(s); everything else passes through.
  always_comb begin
    merged = old_word;
    case (stype)
      ST_SB: begin
        case (addr_lo)
          2'b00:   merged[BYTE0_LSB +: 8] = wdata[7:0];
          2'b01:   merged[BYTE1_LSB +: 8] = wdata[7:0];
          2'b10:   merged[BYTE2_LSB +: 8] = wdata[7:0];
          2'b11:   merged[BYTE3_LSB +: 8] = wdata[7:0];
          default: merged = old_word;
        endcase
      end
      ST_SH: begin
        if (addr_lo[1]) begin
          merged[HALF1_LSB +: 16] = wdata;
        end else begin
          merged[HALF0_LSB +: 16] = wdata;
        end
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Multicycle store engine: SW writes directly, SH/SB read-merge-write the word.
// Define STORE_UNIT_ALIGN_CHECK_EN to reject misaligned SW/SH requests.
module store_unit
  import store_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  store_unit_if.slave  bus
);

  localparam logic [3:0] LAT_C = 4'(MEM_LAT);

  state_t            state_r;
  stype_t            stype_r;
  logic [1:0]        addr_lo_r;
  logic [15:0]       wdata_r;
  logic [3:0]        cnt_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic              busy_r;
  logic              done_r;
  logic              store_err_r;

  logic [ADDR_W-1:0] word_addr_s;
  logic [31:0]       merged_s;
  logic              req_err_s;

  assign word_addr_s = {bus.Addr[ADDR_W-1:2], 2'b00};

  // Classify the incoming request as rejected before any memory access.
  always_comb begin
    req_err_s = (bus.SType == ST_RSVD);
`ifdef STORE_UNIT_ALIGN_CHECK_EN
    if (((bus.SType == ST_SW) && (bus.Addr[1:0] != 2'b00)) ||
        ((bus.SType == ST_SH) && bus.Addr[0])) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = (bus.SType == ST_RSVD);
    end
`endif
  end

  // The read word is merged as it arrives and lands straight in the write-data register.
  store_merge u_merge (
    .old_word (bus.MemData),
    .wdata    (wdata_r),
    .stype    (stype_r),
    .addr_lo  (addr_lo_r),
    .merged   (merged_s)
  );

  // Control FSM with registered memory strobes and status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= IDLE;
      stype_r     <= ST_SW;
      addr_lo_r   <= 2'b00;
      wdata_r     <= 16'h0000;
      cnt_r       <= 4'd0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      store_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.Start) begin
            stype_r   <= stype_t'(bus.SType);
            addr_lo_r <= bus.Addr[1:0];
            wdata_r   <= bus.WData[15:0];
            busy_r    <= 1'b1;
            if (req_err_s) begin
              state_r     <= DONE;
              done_r      <= 1'b1;
              store_err_r <= 1'b1;
            end else if (bus.SType == ST_SW) begin
              state_r     <= WRITE;
              mem_addr_r  <= word_addr_s;
              mem_wdata_r <= bus.WData;
              mem_write_r <= 1'b1;
            end else begin
              state_r    <= READ;
              mem_addr_r <= word_addr_s;
              mem_read_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          mem_read_r <= 1'b0;
          cnt_r      <= LAT_C;
          state_r    <= WAIT;
        end
        WAIT: begin
          // cnt_r == 1 marks the cycle in which MemData carries the old word.
          if (cnt_r == 4'd1) begin
            cnt_r       <= 4'd0;
            mem_wdata_r <= merged_s;
            mem_write_r <= 1'b1;
            state_r     <= WRITE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        WRITE: begin
          mem_write_r <= 1'b0;
          mem_wdata_r <= 32'h0000_0000;
          done_r      <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          done_r      <= 1'b0;
          store_err_r <= 1'b0;
          busy_r      <= 1'b0;
          mem_addr_r  <= '0;
          state_r     <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 4'd0;
          mem_addr_r  <= '0;
          mem_wdata_r <= 32'h0000_0000;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          store_err_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MemAddr  = mem_addr_r;
  assign bus.MemWData = mem_wdata_r;
  assign bus.MemRead  = mem_read_r;
  assign bus.MemWrite = mem_write_r;
  assign bus.Busy     = busy_r;
  assign bus.Done     = done_r;
  assign bus.StoreErr = store_err_r;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: two instances (MEM_LAT 1 and 3) run the same vectors.
`timescale 1ns/1ps
module tb_store_unit;
  import store_pkg::*;

  localparam int ADDR_W = 32;
  localparam logic [31:0] GARB = 32'hA5A5_5A5A;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  store_unit_if #(.ADDR_W(ADDR_W)) bus1 ();
  store_unit_if #(.ADDR_W(ADDR_W)) bus3 ();

  store_unit #(.MEM_LAT(1), .ADDR_W(ADDR_W)) u_dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1.slave));
  store_unit #(.MEM_LAT(3), .ADDR_W(ADDR_W)) u_dut3 (.Clk(Clk), .Reset(Reset), .bus(bus3.slave));

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h1122_3344;
      32'h0000_0020: return 32'h5566_7788;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Memory model: read data is valid only in the cycle MEM_LAT after MemRead.
  int cnt1 = 0, cnt3 = 0;
  logic [31:0] ra1 = 32'h0, ra3 = 32'h0;
  always @(negedge Clk) begin
    if (Reset) begin cnt1 = 0; cnt3 = 0; end
    if (cnt1 != 0) begin cnt1--; bus1.MemData = (cnt1 == 0) ? mem_word(ra1) : GARB; end
    else bus1.MemData = GARB;
    if (bus1.MemRead) begin cnt1 = 1; ra1 = bus1.MemAddr; end
    if (cnt3 != 0) begin cnt3--; bus3.MemData = (cnt3 == 0) ? mem_word(ra3) : GARB; end
    else bus3.MemData = GARB;
    if (bus3.MemRead) begin cnt3 = 3; ra3 = bus3.MemAddr; end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  task automatic set_in(input logic s, input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
    bus1.Start = s; bus1.SType = st; bus1.Addr = a; bus1.WData = d;
    bus3.Start = s; bus3.SType = st; bus3.Addr = a; bus3.WData = d;
  endtask

  // Per-instance observation records.
  int rd_n[2], rd_c[2], wr_n[2], wr_c[2], dn_n[2], dn_c[2], bad_n[2];
  logic [31:0] wr_d[2], wr_a[2];
  logic err_d[2];

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      rd_n[d] = 0; rd_c[d] = 0; wr_n[d] = 0; wr_c[d] = 0; dn_n[d] = 0; dn_c[d] = 0;
      bad_n[d] = 0; wr_d[d] = 32'h0; wr_a[d] = 32'h0; err_d[d] = 1'b0;
    end
  endtask

  task automatic observe(input int d, input int cyc, input logic mr, input logic mw, input logic bs,
                         input logic dn, input logic se, input logic [31:0] ma, input logic [31:0] mwd,
                         input int done_e, input logic [31:0] addr_e, input bit chk_addr);
    if (mr) begin rd_n[d]++; rd_c[d] = cyc; end
    if (mw) begin wr_n[d]++; wr_c[d] = cyc; wr_d[d] = mwd; wr_a[d] = ma; end
    else if (mwd != 32'h0) bad_n[d]++;
    if (dn) begin dn_n[d]++; dn_c[d] = cyc; err_d[d] = se; end
    else if (se) bad_n[d]++;
    if (cyc <= done_e) begin
      if (!bs) bad_n[d]++;
      if (chk_addr && (ma != addr_e)) bad_n[d]++;
    end else if (bs || (ma != 32'h0)) bad_n[d]++;
  endtask

  typedef struct {
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] exp_d;
    logic [31:0] exp_a;
  } vec_t;

  task automatic run_vec(input vec_t v, input bit poke, input string tag);
    int lat, done_e, wr_e;
    bit rmw;
    int de[2];
    rmw = !v.err && (v.st != ST_SW);
    de[0] = v.err ? 1 : (rmw ? 4 : 2);
    de[1] = v.err ? 1 : (rmw ? 6 : 2);
    clear_mon();
    @(negedge Clk);
    set_in(1'b1, v.st, v.addr, v.wdata);
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (c == 1) set_in(1'b0, ~v.st, v.addr ^ 32'h40, ~v.wdata);
      if (poke && c == 2) set_in(1'b1, ST_SW, 32'h20, 32'h7777_7777);
      if (poke && c == 3) set_in(1'b0, ST_SW, 32'h20, 32'h7777_7777);
      observe(0, c, bus1.MemRead, bus1.MemWrite, bus1.Busy, bus1.Done, bus1.StoreErr,
              bus1.MemAddr, bus1.MemWData, de[0], v.exp_a, !v.err);
      observe(1, c, bus3.MemRead, bus3.MemWrite, bus3.Busy, bus3.Done, bus3.StoreErr,
              bus3.MemAddr, bus3.MemWData, de[1], v.exp_a, !v.err);
    end
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      done_e = de[d];
      wr_e = rmw ? lat + 2 : 1;
      chk($sformatf("%s_L%0d_rd_count", tag, lat), 32'(rd_n[d]), rmw ? 32'd1 : 32'd0);
      if (rmw) chk($sformatf("%s_L%0d_rd_cycle", tag, lat), 32'(rd_c[d]), 32'd1);
      chk($sformatf("%s_L%0d_wr_count", tag, lat), 32'(wr_n[d]), v.err ? 32'd0 : 32'd1);
      if (!v.err) begin
        chk($sformatf("%s_L%0d_wr_cycle", tag, lat), 32'(wr_c[d]), 32'(wr_e));
        chk($sformatf("%s_L%0d_wr_data", tag, lat), wr_d[d], v.exp_d);
        chk($sformatf("%s_L%0d_wr_addr", tag, lat), wr_a[d], v.exp_a);
      end
      chk($sformatf("%s_L%0d_done_count", tag, lat), 32'(dn_n[d]), 32'd1);
      chk($sformatf("%s_L%0d_done_cycle", tag, lat), 32'(dn_c[d]), 32'(done_e));
      chk($sformatf("%s_L%0d_store_err", tag, lat), {31'h0, err_d[d]}, {31'h0, v.err});
      chk($sformatf("%s_L%0d_idle_hold_violations", tag, lat), 32'(bad_n[d]), 32'd0);
    end
  endtask

  vec_t vecs[12];

  initial begin
    bit align_en;
`ifdef STORE_UNIT_ALIGN_CHECK_EN
    align_en = 1'b1;
`else
    align_en = 1'b0;
`endif
    vecs[0]  = '{ST_SW,   32'h10, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 32'h10};
    vecs[1]  = '{ST_SB,   32'h13, 32'h0000_00AB, 1'b0, 32'h1122_33AB, 32'h10};
    vecs[2]  = '{ST_SB,   32'h10, 32'h0000_00AB, 1'b0, 32'hAB22_3344, 32'h10};
    vecs[3]  = '{ST_SB,   32'h11, 32'hFFFF_FF5A, 1'b0, 32'h115A_3344, 32'h10};
    vecs[4]  = '{ST_SB,   32'h22, 32'h0000_00C3, 1'b0, 32'h5566_C388, 32'h20};
    vecs[5]  = '{ST_SH,   32'h12, 32'h0000_CAFE, 1'b0, 32'h1122_CAFE, 32'h10};
    vecs[6]  = '{ST_SH,   32'h10, 32'h0000_CAFE, 1'b0, 32'hCAFE_3344, 32'h10};
    vecs[7]  = '{ST_SH,   32'h22, 32'h1234_BEEF, 1'b0, 32'h5566_BEEF, 32'h20};
    vecs[8]  = '{ST_SW,   32'h11, 32'h0102_0304, align_en, 32'h0102_0304, 32'h10};
    vecs[9]  = '{ST_SH,   32'h13, 32'h0000_ABCD, align_en, 32'h1122_ABCD, 32'h10};
    vecs[10] = '{ST_RSVD, 32'h10, 32'h1234_5678, 1'b1, 32'h0, 32'h0};
    vecs[11] = '{ST_SW,   32'hFFFF_FFFC, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 32'hFFFF_FFFC};

    Reset = 1'b1;
    set_in(1'b0, ST_SW, 32'h0, 32'h0);
    repeat (3) @(negedge Clk);
    chk("reset_L1_outputs", {26'h0, bus1.Busy, bus1.Done, bus1.StoreErr, bus1.MemRead, bus1.MemWrite,
        |bus1.MemWData}, 32'h0);
    chk("reset_L1_memaddr", bus1.MemAddr, 32'h0);
    chk("reset_L3_outputs", {26'h0, bus3.Busy, bus3.Done, bus3.StoreErr, bus3.MemRead, bus3.MemWrite,
        |bus3.MemWData}, 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset in the WAIT state of an SB abandons the write.
    clear_mon();
    @(negedge Clk);
    set_in(1'b1, ST_SB, 32'h13, 32'h0000_00AB);
    @(negedge Clk);
    set_in(1'b0, ST_SW, 32'h0, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst_mid_L1_outputs", {26'h0, bus1.Busy, bus1.Done, bus1.StoreErr, bus1.MemRead, bus1.MemWrite,
        |bus1.MemWData}, 32'h0);
    chk("rst_mid_L1_memaddr", bus1.MemAddr, 32'h0);
    chk("rst_mid_L3_outputs", {26'h0, bus3.Busy, bus3.Done, bus3.StoreErr, bus3.MemRead, bus3.MemWrite,
        |bus3.MemWData}, 32'h0);
    chk("rst_mid_L3_memaddr", bus3.MemAddr, 32'h0);
    for (int c = 4; c <= 10; c++) begin
      @(negedge Clk);
      observe(0, c, bus1.MemRead, bus1.MemWrite, bus1.Busy, bus1.Done, bus1.StoreErr,
              bus1.MemAddr, bus1.MemWData, 0, 32'h0, 1'b0);
      observe(1, c, bus3.MemRead, bus3.MemWrite, bus3.Busy, bus3.Done, bus3.StoreErr,
              bus3.MemAddr, bus3.MemWData, 0, 32'h0, 1'b0);
    end
    chk("rst_mid_L1_no_write", 32'(wr_n[0] + rd_n[0] + dn_n[0] + bad_n[0]), 32'd0);
    chk("rst_mid_L3_no_write", 32'(wr_n[1] + rd_n[1] + dn_n[1] + bad_n[1]), 32'd0);
    run_vec(vecs[0], 1'b0, "after_rst_sw");

    // A Start pulse while busy is dropped; only the first store writes.
    run_vec(vecs[1], 1'b1, "busy_poke");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
